// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcodes, format codes and widths shared by the immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational map from a 32-bit instruction to {imm, fmt, illegal}.
//   i_instr   raw instruction
//   o_imm     immediate sign-extended from bit 31 to XLEN
//   o_fmt     instruction format code
//   o_illegal opcode not recognised
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt,
    output logic            o_illegal
);

    logic [31:0] w_imm;

    always_comb begin
        w_imm     = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (i_instr[6:0])
            OP_R: o_fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                o_fmt = FMT_I;
                w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                o_fmt = FMT_S;
                w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                o_fmt = FMT_B;
                w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt = FMT_U;
                w_imm = {i_instr[31:12], 12'h000};
            end
            OP_JAL: begin
                o_fmt = FMT_J;
                w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            default: o_illegal = 1'b1;
        endcase
    end

    // Every format's 32-bit immediate already has bit 31 as its sign, so a
    // signed resize covers the XLEN=64 extension.
    assign o_imm = XLEN'($signed(w_imm));

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decodes instruction immediates and queues them in a small FIFO.
//   clk, rst                 clock, async active-high reset
//   flush                    drop all queued entries (wins over push/pop)
//   in_valid/in_ready/in_instr   instruction input handshake
//   out_valid/out_ready      head entry handshake
//   out_imm/out_fmt/out_illegal  head entry fields (0/NONE/0 when empty)
//   illegal_cnt              saturating count of accepted illegal instructions
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0]  r_imm [DEPTH];
    fmt_e             r_fmt [DEPTH];
    logic [DEPTH-1:0] r_ill;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    logic [XLEN-1:0]  w_imm;
    fmt_e             w_fmt;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr   (in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_ill)
    );

    assign in_ready  = r_cnt != (AW+1)'(DEPTH);
    assign out_valid = r_cnt != '0;
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_ill_cnt <= '0;
        end else begin
            if (flush) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wr <= r_wr + 1'b1;
                if (w_pop) r_rd <= r_rd + 1'b1;
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            if (w_push && w_ill && r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm[r_wr] <= w_imm;
            r_fmt[r_wr] <= w_fmt;
            r_ill[r_wr] <= w_ill;
        end
    end

    assign out_imm     = out_valid ? r_imm[r_rd] : '0;
    assign out_fmt     = out_valid ? r_fmt[r_rd] : FMT_NONE;
    assign out_illegal = out_valid && r_ill[r_rd];
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: drives a 32-bit and a 64-bit/2-bit-counter instance in lockstep against a queue model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [1:0]  b_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .illegal_cnt(a_cnt)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .illegal_cnt(b_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int ref_fmt(input logic [31:0] x);
        case (x[6:0])
            7'h33: return 0;
            7'h13, 7'h03, 7'h67, 7'h73: return 1;
            7'h23: return 2;
            7'h63: return 3;
            7'h37, 7'h17: return 4;
            7'h6F: return 5;
            default: return 7;
        endcase
    endfunction

    // Immediates built arithmetically from a sign-extended copy of the word.
    function automatic logic [63:0] ref_imm(input logic [31:0] x);
        int si;
        longint s;
        si = int'(x);
        s = si;
        case (ref_fmt(x))
            1: return s >>> 20;
            2: return ((s >>> 25) << 5) | longint'(x[11:7]);
            3: return ((s >>> 31) << 12) | (longint'(x[7]) << 11) | (longint'(x[30:25]) << 5) | (longint'(x[11:8]) << 1);
            4: return (s >>> 12) << 12;
            5: return ((s >>> 31) << 20) | (longint'(x[19:12]) << 12) | (longint'(x[20]) << 11) | (longint'(x[30:21]) << 1);
            default: return 64'd0;
        endcase
    endfunction

    logic [31:0] q[$];
    int m_cnt32 = 0;
    int m_cnt2 = 0;

    always @(posedge clk or posedge rst) begin
        bit full;
        if (rst) begin
            q.delete();
            m_cnt32 = 0;
            m_cnt2 = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            full = q.size() == 2;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && !full) begin
                q.push_back(in_instr);
                if (ref_fmt(in_instr) == 7) begin
                    if (m_cnt32 < 65535) m_cnt32++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        v;
        logic [63:0] e;
        int          f;
        v = q.size() > 0;
        e = v ? ref_imm(q[0]) : 64'd0;
        f = v ? ref_fmt(q[0]) : 7;
        check("a_valid", a_out_valid, v);
        check("a_ready", a_in_ready, q.size() < 2);
        check("a_imm", a_out_imm, e[31:0]);
        check("a_fmt", a_out_fmt, f);
        check("a_ill", a_out_illegal, v && f == 7);
        check("a_cnt", a_cnt, m_cnt32);
        check("b_valid", b_out_valid, v);
        check("b_ready", b_in_ready, q.size() < 2);
        check("b_imm", b_out_imm, e);
        check("b_fmt", b_out_fmt, f);
        check("b_ill", b_out_illegal, v && f == 7);
        check("b_cnt", b_cnt, m_cnt2);
    end

    task automatic send(input logic [31:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = x;
        while (!a_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n == 20) begin
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1 within 20 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", a_out_valid, 0);
        check("rst_fmt", a_out_fmt, 7);
        check("rst_imm", a_out_imm, 0);
        check("rst_cnt", a_cnt, 0);
        @(negedge clk);
        check("rst_ready", a_in_ready, 1);

        out_ready = 1'b1;
        send(32'hFFF00093);
        check("t1_valid", a_out_valid, 1);
        check("t1_imm", a_out_imm, 32'hFFFFFFFF);
        check("t1_fmt", a_out_fmt, 1);
        check("t1_ill", a_out_illegal, 0);
        check("t1_imm64", b_out_imm, 64'hFFFFFFFFFFFFFFFF);

        send(32'hFE000EE3);
        check("t2_b_imm", a_out_imm, 32'hFFFFFFFC);
        check("t2_b_fmt", a_out_fmt, 3);
        send(32'h0010006F);
        check("t2_j_imm", a_out_imm, 32'h00000800);
        check("t2_j_fmt", a_out_fmt, 5);
        send(32'h123450B7);
        check("t2_u_imm", a_out_imm, 32'h12345000);
        check("t2_u_fmt", a_out_fmt, 4);

        send(32'h800000B7);
        check("t3_imm64", b_out_imm, 64'hFFFFFFFF80000000);
        check("t3_imm32", a_out_imm, 32'h80000000);
        check("t3_fmt", b_out_fmt, 4);

        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00500113;
        @(negedge clk);
        in_instr = 32'h0020A223;
        @(negedge clk);
        in_instr = 32'hFFFFF197;
        check("t4_full", a_in_ready, 0);
        check("t4_head_a", a_out_imm, 32'd5);
        repeat (2) @(negedge clk);
        check("t4_held", a_in_ready, 0);
        check("t4_head_a2", a_out_imm, 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_head_b", a_out_imm, 32'd4);
        check("t4_fmt_b", a_out_fmt, 2);
        @(negedge clk);
        check("t4_head_c", a_out_imm, 32'hFFFFF000);
        check("t4_fmt_c", a_out_fmt, 4);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_empty", a_out_valid, 0);

        in_instr = 32'h00000000;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("t5_ill", a_out_illegal, 1);
        check("t5_imm", a_out_imm, 0);
        check("t5_fmt", a_out_fmt, 7);
        check("t5_cnt16", a_cnt, 5);
        check("t5_cnt2", b_cnt, 3);

        @(negedge clk);
        out_ready = 1'b0;
        send(32'h00500113);
        send(32'h0020A223);
        check("t6_full", a_in_ready, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00000000;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("t6_flushed", a_out_valid, 0);
        check("t6_ready", a_in_ready, 1);
        check("t6_cnt", a_cnt, 5);
        @(negedge clk);
        check("t6_gone", a_out_valid, 0);

        out_ready = 1'b0;
        send(32'h123450B7);
        check("t6_pre_rst", a_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_valid", a_out_valid, 0);
        check("t6_arst_fmt", a_out_fmt, 7);
        check("t6_arst_imm", b_out_imm, 0);
        check("t6_arst_cnt", a_cnt, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_post_ready", a_in_ready, 1);
        out_ready = 1'b1;
        send(32'h0010006F);
        check("t6_resume", a_out_imm, 32'h00000800);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, buffered immediate generator for the RV decode path.
- Accepts 32-bit instructions over a valid/ready handshake.
- Decodes the instruction format and produces a correctly sign-extended XLEN-wide immediate, with B/J bit 0 = 0 and U-type shifted by 12.
- Flags illegal opcodes and queues results in a small FIFO so fetch and execute can be decoupled.
- Sits between fetch and the register-read/execute stage as the first pipelined decode element.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
DEPTH, 2, output FIFO entries; power of two, at least 2.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock, all state on the rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous; discards all queued entries.
in_valid  input  1  instruction present.
in_ready  output  1  stage can accept; equals not full.
in_instr  input  32  raw instruction.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer takes head entry.
out_imm  output  XLEN  extended immediate of head entry.
out_fmt  output  3  format code of head entry: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
out_illegal  output  1  head entry has an unknown opcode.
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers and count cleared, illegal_cnt=0. Outputs go to out_valid=0, out_imm=0, out_fmt=7, out_illegal=0. in_ready=1 the first cycle after rst deasserts. Reset mid-transfer drops all entries.
- Accept: an entry is pushed on in_valid && in_ready. Pop: on out_valid && out_ready.
- Latency: exactly 1 cycle. An instruction accepted at edge N is visible at the head after edge N when the FIFO was empty. There is no combinational path from in_instr to out_*.
- Simultaneous push and pop when not full: both occur and the count is unchanged. When full, in_ready=0, so no push occurs even if out_ready=1 in that cycle. in_ready has no combinational dependence on out_ready.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.
- flush has priority over push and pop. Next cycle the FIFO is empty and the instruction offered in the flush cycle is dropped. illegal_cnt is not cleared and does not count the dropped instruction.
- Decode uses opcode in_instr[6:0]. sext() denotes sign extension from bit 31 to XLEN.
  - 0110011: R, imm=0.
  - 0010011, 0000011, 1100111, 1110011: I, sext(in[31:20]).
  - 0100011: S, sext({in[31:25],in[11:7]}).
  - 1100011: B, sext({in[31],in[7],in[30:25],in[11:8],1'b0}).
  - 0110111, 0010111: U, sext({in[31:12],12'h000}).
  - 1101111: J, sext({in[31],in[19:12],in[20],in[30:21],1'b0}).
  - Any other opcode: fmt=7, imm=0, illegal=1.
- illegal_cnt increments on each accepted illegal instruction and holds at its maximum (all ones).
- The stored entry is {imm, fmt, illegal}. Decode happens before storage.
- When out_valid=0: out_imm=0, out_fmt=7, out_illegal=0.

Decomposition:
- Package imm_gen_pkg holds:
  - Opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - Format codes FMT_R through FMT_NONE.
  - FMT_W=3.
- One combinational sub-module, imm_decode, maps instruction to {imm, fmt, illegal} and is parametrised by XLEN.
- FIFO storage, pointers and the counter stay in imm_gen_stage.

Test Plan:
1. XLEN=32, push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> one cycle later out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
2. Push 0xFE000EE3 (beq -4), then 0x0010006F (jal +2048), then 0x123450B7 (lui) -> imm 0xFFFFFFFC fmt 3, 0x00000800 fmt 5, 0x12345000 fmt 4, in order on consecutive cycles.
3. XLEN=64, push 0x800000B7 -> out_imm=0xFFFFFFFF80000000, fmt 4.
4. DEPTH=2, out_ready=0, offer 3 instructions back-to-back -> in_ready=0 after 2 accepted and the third is held. Raise out_ready -> all 3 emerge in order with no loss or duplication.
5. Push 0x00000000 five times -> out_illegal=1, out_imm=0, fmt 7, illegal_cnt=5. With CNT_W=2 the count saturates at 3.
6. With 2 entries queued, assert flush together with in_valid -> out_valid=0 next cycle and the flushed instruction never appears. Repeat with async rst pulsed between edges -> outputs reset immediately.
